// File: rtl/rv_out_uart.sv
// Captures changed core observation words into a FIFO and streams them as 5-byte 8N1 frames; start bit one cycle after pop.
// Backpressure: capture while the FIFO is full drops the record (sticky overflow) and retries a persisting value.
module rv_out_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_dat,
  input  logic                      pop,
  output logic [W-1:0]              pop_dat,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push & (count != FULL_CNT);
  assign do_pop  = pop & (count != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module rv_out_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   core_out,
  input  logic                          core_out_type,
  input  logic                          core_exit,
  input  logic                          cap_en,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } rec_t;

  state_t      state, state_nxt;
  rec_t        rec, rec_nxt, cap_rec, fifo_head;
  logic [15:0] baud, baud_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt, byte_idx, byte_idx_nxt;
  logic [31:0] last_out;
  logic        last_type, have_last, exit_seen;
  logic        capture, push, pop, full, empty;
  logic [7:0]  cur_byte;

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);
  assign capture = cap_en & ~exit_seen &
                   (core_exit | ~have_last | (core_out != last_out) | (core_out_type != last_type));
  assign push  = capture & ~full;
  assign pop   = (state == IDLE) & ~empty;
  assign busy  = ~empty | (state != IDLE);
  assign done  = exit_seen & empty & (state == IDLE);

  always_comb begin
    cap_rec.data = core_out;
    cap_rec.kind = core_exit ? 2'd2 : {1'b0, core_out_type};
  end

  rv_out_fifo #(.W($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cap_rec),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .count    (fifo_count)
  );

  // last_* only advance on a successful push so a dropped value is retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_out  <= '0;
      last_type <= 1'b0;
      have_last <= 1'b0;
      exit_seen <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        last_out  <= core_out;
        last_type <= core_out_type;
        have_last <= 1'b1;
        if (core_exit) exit_seen <= 1'b1;
      end
      if (capture & full) overflow <= 1'b1;
    end
  end

  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = (rec.kind == 2'd2) ? 8'h58 : (rec.kind == 2'd1) ? 8'h50 : 8'h44;
      3'd1:    cur_byte = rec.data[31:24];
      3'd2:    cur_byte = rec.data[23:16];
      3'd3:    cur_byte = rec.data[15:8];
      default: cur_byte = rec.data[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rec      <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      rec      <= rec_nxt;
      baud     <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rec_nxt      = rec;
    baud_nxt     = baud;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    uart_tx      = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          rec_nxt      = fifo_head;
          byte_idx_nxt = '0;
          baud_nxt     = BAUD_MAX;
          state_nxt    = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud == '0) begin
          baud_nxt    = BAUD_MAX;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          baud_nxt = baud - 1'b1;
        end
      end
      DATA: begin
        uart_tx = cur_byte[bit_idx];
        if (baud == '0) begin
          baud_nxt = BAUD_MAX;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end else begin
          baud_nxt = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (byte_idx != 3'd4) begin
            byte_idx_nxt = byte_idx + 1'b1;
            baud_nxt     = BAUD_MAX;
            state_nxt    = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
